sd_sector_buffer: RTL and testbench
===================================

Name: sd_sector_buffer

Overview:
- Sits directly downstream of the SRAM image reader, on the consuming side of the sd_lba/sd_rd/sd_ack/sd_buff_* sector handshake.
- Accepts a sector request from the disk controller (FDC side) and issues the read.
- Captures the 512 streamed bytes into an internal 512x8 buffer, then serves them to the controller through a random-access byte port.
- Read-only in this revision: sd_wr is permanently 0.

Parameters:
- SECTOR_BYTES, 512: bytes per sector. Fixed; sets the 9-bit address width.
- ACK_TIMEOUT, 65535: clk_i cycles to wait for sd_ack after raising sd_rd[0]. Fits in 16 bits.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  1  one-cycle sector request pulse from the controller.
- lba_i  in  32  sector number, sampled when req_i is accepted.
- busy_o  out  1  request in progress.
- done_o  out  1  one-cycle pulse on successful sector capture.
- err_o  out  1  one-cycle pulse on timeout or short transfer.
- valid_o  out  1  buffer holds a complete, good sector.
- rd_addr_i  in  9  buffer read address.
- rd_data_o  out  8  buffer data; registered, 1-cycle latency.
- sd_lba  out  32  latched LBA toward the image reader.
- sd_rd  out  2  bit0 = read request; bit1 always 0.
- sd_wr  out  2  always 2'b00.
- sd_ack  in  1  transfer acknowledge from the image reader.
- sd_buff_addr  in  9  byte index of the incoming byte.
- sd_buff_dout  in  8  incoming byte.
- sd_buff_wr  in  1  incoming byte strobe.
- sd_buff_din  out  8  registered buffer[sd_buff_addr]; unused by read path, driven for completeness.

Behaviour:
Reset values
- busy_o=0, done_o=0, err_o=0, valid_o=0, sd_rd=0, sd_wr=0, sd_lba=0, rd_data_o=0, sd_buff_din=0.
- Byte counter = 0, timeout counter = 0, state = IDLE.
- Buffer contents are undefined after reset.

States: IDLE, REQ, XFER, CHECK.

IDLE
- On req_i=1: latch sd_lba<=lba_i, set valid_o<=0, busy_o<=1, sd_rd[0]<=1, clear the byte counter and timeout counter, go to REQ.
- req_i in any other state is ignored; no queueing.

REQ
- sd_rd[0] held at 1 and the timeout counter increments each cycle.
- On sd_ack=1: sd_rd[0]<=0, go to XFER.
- If the counter reaches ACK_TIMEOUT first: sd_rd[0]<=0, err_o pulse, busy_o<=0, go to IDLE.

XFER
- Each cycle with sd_buff_wr=1: buffer[sd_buff_addr]<=sd_buff_dout, byte counter +1 (10-bit, saturates at 512).
- Duplicate addresses are still counted.
- On sd_ack=0: go to CHECK.
- If sd_buff_wr and the sd_ack fall occur in the same cycle, the byte is still captured and counted.

CHECK (one cycle)
- Byte counter == 512: valid_o<=1, done_o pulse.
- Otherwise: err_o pulse, valid_o stays 0.
- In both cases busy_o<=0, go to IDLE.

Latency and bus timing
- Earliest completion: done_o 1 cycle after the sd_ack falling edge is sampled.
- sd_buff_wr strobes arrive at least 1 cycle apart (upstream pace is 1 byte per 4 cycles); the block also accepts back-to-back strobes.

Read port
- rd_data_o <= buffer[rd_addr_i] every cycle, independent of state.
- Data read while valid_o=0 is undefined.

Boundary and stray-input rules
- sd_ack already high in IDLE: ignored.
- sd_buff_wr outside XFER: ignored; no buffer write, no count.
- A new request clears valid_o immediately, so stale sector data is never advertised.
- reset_i mid-transfer returns every output to its reset value on the next edge and drops sd_rd at once.

Decomposition:
- Package sd_if_pkg holds:
  - the state typedef for IDLE/REQ/XFER/CHECK;
  - SECTOR_BYTES, ADDR_W=9 and CNT_W=10 constants.
- The package is shared with the image reader.
- One sub-module, sector_ram_dp: 512x8 with one write port, two synchronous read ports (rd_addr_i and sd_buff_addr), inferring block RAM.

Test Plan:
- Nominal: req_i with lba_i=0x0000_0023; model acks after 5 cycles and streams bytes 0..511 with data=addr^0x5A at 1 per 4 cycles -> sd_lba=0x23, sd_rd drops on ack, done_o once, valid_o=1, and rd_addr_i=0x1FF returns 0xA5 next cycle.
- Timeout: ACK_TIMEOUT=16, model never acks -> err_o on cycle 16 after req, sd_rd=0, busy_o=0, valid_o=0.
- Short transfer: ack then only 300 strobes, ack falls -> err_o pulse, valid_o=0, no done_o.
- Request while busy: second req_i with lba_i=0x99 mid-XFER -> ignored, sd_lba stays 0x23, single done_o.
- Reset mid-XFER at byte 100 -> next cycle all outputs at reset values; a subsequent full request completes normally.
- Stray strobes: sd_buff_wr pulses in IDLE with addr 0, data 0xFF, after a good sector whose byte 0 is 0x5A -> rd_data_o at addr 0 is still 0x5A.

Source files
------------

// File: rtl/sd_if_pkg.sv
// Shared definitions for the SD sector handshake between the image reader and its consumers.
package sd_if_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int ADDR_W       = 9;
   localparam int CNT_W        = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_XFER  = 2'd2,
      ST_CHECK = 2'd3
   } sd_state_e;

   // Byte counter that sticks at one full sector instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_W'(SECTOR_BYTES)) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

endpackage

// File: rtl/sector_ram_dp.sv
// 512x8 sector store: one write port and two registered read ports, shaped for block RAM inference.
module sector_ram_dp
   import sd_if_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [7:0]        a_data,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [7:0]        b_data
);

   logic [7:0] mem_r [SECTOR_BYTES];

   // Array write, kept free of reset so it maps onto RAM primitives.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Output registers carry the reset so both read ports come up at zero.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         a_data <= 8'd0;
         b_data <= 8'd0;
      end else begin
         a_data <= mem_r[a_addr];
         b_data <= mem_r[b_addr];
      end
   end

endmodule

// File: rtl/sd_sector_buffer.sv
// Requests one sector from the image reader, captures the streamed bytes and serves them by address.
module sd_sector_buffer
   import sd_if_pkg::*;
#(
   parameter int ACK_TIMEOUT = 65535
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_i,
   input  logic [31:0]       lba_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              valid_o,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [7:0]        rd_data_o,
   output logic [31:0]       sd_lba,
   output logic [1:0]        sd_rd,
   output logic [1:0]        sd_wr,
   input  logic              sd_ack,
   input  logic [ADDR_W-1:0] sd_buff_addr,
   input  logic [7:0]        sd_buff_dout,
   input  logic              sd_buff_wr,
   output logic [7:0]        sd_buff_din
);

   localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

   sd_state_e        state_r, state_s;
   logic             busy_r, busy_s, done_r, done_s, err_r, err_s;
   logic             valid_r, valid_s, rd_req_r, rd_req_s, ram_we_s;
   logic [31:0]      lba_r, lba_s;
   logic [CNT_W-1:0] byte_cnt_r, byte_cnt_s;
   logic [15:0]      tmo_cnt_r, tmo_cnt_s;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s    = state_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      err_s      = 1'b0;
      valid_s    = valid_r;
      rd_req_s   = rd_req_r;
      lba_s      = lba_r;
      byte_cnt_s = byte_cnt_r;
      tmo_cnt_s  = tmo_cnt_r;
      ram_we_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_i) begin
               lba_s      = lba_i;
               valid_s    = 1'b0;
               busy_s     = 1'b1;
               rd_req_s   = 1'b1;
               byte_cnt_s = '0;
               tmo_cnt_s  = 16'd0;
               state_s    = ST_REQ;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (sd_ack) begin
               rd_req_s  = 1'b0;
               state_s   = ST_XFER;
            end else if (tmo_cnt_r == TMO_LAST) begin
               rd_req_s  = 1'b0;
               err_s     = 1'b1;
               busy_s    = 1'b0;
               state_s   = ST_IDLE;
            end else begin
               tmo_cnt_s = tmo_cnt_r + 16'd1;
            end
         end
         ST_XFER: begin
            // A strobe coinciding with the ack fall is still a valid byte.
            if (sd_buff_wr) begin
               ram_we_s   = 1'b1;
               byte_cnt_s = sat_inc(byte_cnt_r);
            end else begin
               ram_we_s   = 1'b0;
            end
            if (!sd_ack) begin
               state_s = ST_CHECK;
            end else begin
               state_s = ST_XFER;
            end
         end
         ST_CHECK: begin
            if (byte_cnt_r == CNT_W'(SECTOR_BYTES)) begin
               valid_s = 1'b1;
               done_s  = 1'b1;
            end else begin
               valid_s = 1'b0;
               err_s   = 1'b1;
            end
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            busy_s   = 1'b0;
            rd_req_s = 1'b0;
            state_s  = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         valid_r    <= 1'b0;
         rd_req_r   <= 1'b0;
         lba_r      <= 32'd0;
         byte_cnt_r <= '0;
         tmo_cnt_r  <= 16'd0;
      end else begin
         state_r    <= state_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         err_r      <= err_s;
         valid_r    <= valid_s;
         rd_req_r   <= rd_req_s;
         lba_r      <= lba_s;
         byte_cnt_r <= byte_cnt_s;
         tmo_cnt_r  <= tmo_cnt_s;
      end
   end

   sector_ram_dp u_ram (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .wr_en   (ram_we_s),
      .wr_addr (sd_buff_addr),
      .wr_data (sd_buff_dout),
      .a_addr  (rd_addr_i),
      .a_data  (rd_data_o),
      .b_addr  (sd_buff_addr),
      .b_data  (sd_buff_din)
   );

   assign busy_o  = busy_r;
   assign done_o  = done_r;
   assign err_o   = err_r;
   assign valid_o = valid_r;
   assign sd_lba  = lba_r;
   assign sd_rd   = {1'b0, rd_req_r};
   assign sd_wr   = 2'b00;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Scoreboard bench for sd_sector_buffer with a behavioural image-reader model.
module tb_sd_sector_buffer;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        req_i = 1'b0;
   logic [31:0] lba_i = 32'd0;
   logic        busy_o, done_o, err_o, valid_o;
   logic [8:0]  rd_addr_i = 9'd0;
   logic [7:0]  rd_data_o;
   logic [31:0] sd_lba;
   logic [1:0]  sd_rd, sd_wr;
   logic        sd_ack = 1'b0;
   logic [8:0]  sd_buff_addr = 9'd0;
   logic [7:0]  sd_buff_dout = 8'd0;
   logic        sd_buff_wr = 1'b0;
   logic [7:0]  sd_buff_din;

   int total = 0;
   int bad = 0;
   logic [1:0] evq[$];
   logic [7:0] rdq[$];

   sd_sector_buffer #(.ACK_TIMEOUT(16)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .lba_i(lba_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .valid_o(valid_o),
      .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .sd_lba(sd_lba),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
      .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Completion events ({done,err}) are matched against the queued expectations.
   always @(negedge clk_i) begin
      if (done_o || err_o) begin
         if (evq.size() == 0) begin
            chk("unexp_evt", {30'd0, done_o, err_o}, 32'd0);
         end else begin
            chk("evt", {30'd0, done_o, err_o}, {30'd0, evq.pop_front()});
         end
      end
   end

   task automatic do_req(input logic [31:0] lba);
      step();
      req_i = 1'b1;
      lba_i = lba;
      step();
      req_i = 1'b0;
   endtask

   task automatic wait_evt();
      int n = 0;
      while (evq.size() != 0 && n < 10) begin
         step();
         n++;
      end
      chk("evt_seen", evq.size(), 32'd0);
   endtask

   task automatic rd_chk(input logic [8:0] addr, input logic [7:0] exp);
      rd_addr_i = addr;
      rdq.push_back(exp);
      step();
      chk("rd_data", {24'd0, rd_data_o}, {24'd0, rdq.pop_front()});
   endtask

   task automatic chk_reset_outs();
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_sd_rd", {28'd0, sd_rd, sd_wr}, 32'd0);
      chk("rst_lba", sd_lba, 32'd0);
      chk("rst_rdata", {16'd0, rd_data_o, sd_buff_din}, 32'd0);
   endtask

   // Image-reader model: ack after 5 cycles, stream bytes addr^0x5A at 1 per 4 cycles.
   task automatic serve(input int nbytes, input int req_at, input int rst_at);
      int w = 0;
      while (!sd_rd[0] && w < 20) begin
         step();
         w++;
      end
      chk("rd_raised", {30'd0, sd_rd}, 32'd1);
      repeat (5) step();
      sd_ack = 1'b1;
      step();
      chk("rd_drop", {30'd0, sd_rd}, 32'd0);
      chk("busy_xfer", {31'd0, busy_o}, 32'd1);
      for (int i = 0; i < nbytes; i++) begin
         if (i == rst_at) begin
            reset_i = 1'b1;
            sd_ack  = 1'b0;
            step();
            reset_i = 1'b0;
            chk_reset_outs();
            return;
         end
         if (i == req_at) begin
            req_i = 1'b1;
            lba_i = 32'h99;
         end
         sd_buff_addr = i[8:0];
         sd_buff_dout = i[7:0] ^ 8'h5A;
         sd_buff_wr   = 1'b1;
         step();
         sd_buff_wr = 1'b0;
         req_i      = 1'b0;
         repeat (3) step();
      end
      sd_ack = 1'b0;
      step();
      step();
      wait_evt();
      chk("busy_end", {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) step();
      chk_reset_outs();
      reset_i = 1'b0;
      step();
      chk("idle_busy", {31'd0, busy_o}, 32'd0);

      // Nominal sector
      evq.push_back(2'b10);
      do_req(32'h23);
      chk("req_lba", sd_lba, 32'h23);
      chk("req_busy", {31'd0, busy_o}, 32'd1);
      chk("req_valid", {31'd0, valid_o}, 32'd0);
      serve(512, -1, -1);
      chk("nom_valid", {31'd0, valid_o}, 32'd1);
      rd_chk(9'h1FF, 8'hA5);
      rd_chk(9'h000, 8'h5A);
      rd_chk(9'h123, 8'h79);

      // Second request during XFER is ignored
      evq.push_back(2'b10);
      do_req(32'h23);
      serve(512, 100, -1);
      chk("busy_req_lba", sd_lba, 32'h23);
      chk("busy_req_valid", {31'd0, valid_o}, 32'd1);

      // Stray strobes in IDLE must not write
      sd_buff_addr = 9'd0;
      sd_buff_dout = 8'hFF;
      sd_buff_wr   = 1'b1;
      repeat (3) step();
      sd_buff_wr = 1'b0;
      rd_chk(9'h000, 8'h5A);
      chk("buff_din", {24'd0, sd_buff_din}, 32'h5A);

      // Short transfer
      evq.push_back(2'b01);
      do_req(32'h40);
      chk("valid_clear", {31'd0, valid_o}, 32'd0);
      serve(300, -1, -1);
      chk("short_valid", {31'd0, valid_o}, 32'd0);

      // Ack timeout
      evq.push_back(2'b01);
      do_req(32'h50);
      n = 0;
      do begin
         step();
         n++;
      end while (!err_o && n < 40);
      chk("tmo_cycles", n, 32'd16);
      chk("tmo_sd_rd", {30'd0, sd_rd}, 32'd0);
      chk("tmo_busy", {31'd0, busy_o}, 32'd0);
      chk("tmo_valid", {31'd0, valid_o}, 32'd0);
      wait_evt();

      // Reset mid-transfer, then a clean sector
      do_req(32'h60);
      serve(512, -1, 100);
      evq.push_back(2'b10);
      do_req(32'h23);
      serve(512, -1, -1);
      chk("post_rst_valid", {31'd0, valid_o}, 32'd1);
      rd_chk(9'h1FF, 8'hA5);

      repeat (4) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
